light_pattern_engine: RTL and testbench
=======================================

Name: light_pattern_engine

Overview:
- Parametrised successor to the 8-LED light pattern generator.
- Drives a WIDTH-bit LED bar with a selectable animated pattern (shift-left, shift-right, bounce, fill).
- Step rate is programmable through an internal prescaler; Start launches or relaunches the pattern and Pause freezes it.
- Sits between the board buttons/switches and the LED outputs; also serves as the ball-travel primitive for the Pong datapath.

Parameters:
- WIDTH, 8, number of LED outputs (≥2).
- DIV_W, 16, width of the step-period input.

Ports:
- Clk  in  1  system clock, all logic on the rising edge.
- Rst  in  1  synchronous, active-low reset.
- Start  in  1  level; sampled every cycle; launches or relaunches the pattern.
- Pause  in  1  level; while high, pattern and prescaler are frozen.
- Mode  in  2  0=shift-left, 1=shift-right, 2=bounce, 3=fill; latched only on Start.
- Div  in  DIV_W  Clk cycles per pattern step; 0 is treated as 1; sampled continuously.
- Out  out  WIDTH  registered LED pattern.
- Busy  out  1  high in RUN or PAUSED.
- Wrap  out  1  one-cycle pulse when a pattern period completes.

Behaviour:
- Reset (Rst=0 at a rising edge) has priority over all inputs.
  - Out=0, Busy=0, Wrap=0.
  - State=IDLE, prescaler=0, dir=left, latched mode=0.
- States:
  - IDLE: Out holds its last value (0 after reset).
  - RUN: pattern advances on each step tick.
  - PAUSED: Out and prescaler are held.
- Start=1 in any state (not reset):
  - Latch Mode and clear the prescaler.
  - Load the initial pattern; Out shows it on the next cycle.
  - Initial patterns: mode 0/2/3 → bit0=1, others 0; mode 1 → bit[WIDTH-1]=1.
  - dir=left.
  - Next state is PAUSED if Pause=1 in the same cycle, else RUN.
  - Start held high re-loads every cycle, so the pattern does not advance.
- RUN:
  - Prescaler counts 0..Div_eff-1, where Div_eff=max(Div,1).
  - Step tick occurs when prescaler==Div_eff-1; the prescaler then returns to 0.
  - Out updates on the same edge as the tick.
  - Div changes take effect immediately. If prescaler ≥ Div_eff-1, treat it as a tick (no long wrap-around).
- Step rules:
  - Shift-left: Out rotates left. When the MSB is set, the next step returns to bit0 and Wrap pulses with that update.
  - Shift-right: mirror image of shift-left; Wrap pulses when bit[WIDTH-1] reloads.
  - Bounce: a single lit bit moves in dir.
    - At bit[WIDTH-1], dir flips to right and the bit moves down on the following step (no hold).
    - At bit0 moving right, dir flips to left and Wrap pulses.
    - Sequence for WIDTH=4: 0001,0010,0100,1000,0100,0010,0001(Wrap),0010…
  - Fill: Out=(Out<<1)|1 until all ones. Next step gives Out=0; the step after gives 0…01 with Wrap.
- Pause:
  - Pause=1 in RUN → PAUSED on the next edge. No step occurs on that edge even if a tick was due.
  - Pause=0 in PAUSED → RUN. The prescaler resumes from its held value.
  - No state effect in IDLE.
- Busy=1 in RUN and PAUSED. Wrap is otherwise 0 and is never asserted in PAUSED or IDLE.
- Wrap does not stop the pattern; it runs until reset. No transition exists back to IDLE except reset.

Decomposition:
- Shared package lpe_pkg:
  - Mode encodings MODE_SHL, MODE_SHR, MODE_BOUNCE, MODE_FILL.
  - State encodings ST_IDLE, ST_RUN, ST_PAUSED.
- One sub-module, lpe_prescaler:
  - Contains the DIV_W counter with clear, hold and Div_eff clamping.
  - Outputs a tick.
- Pattern next-state logic and the FSM stay in the top module.

Test Plan:
- Reset: Rst=0 for 2 cycles with Start=1 → Out=0, Busy=0, Wrap=0 throughout; state IDLE after release.
- Shift-left, WIDTH=8, Div=2, Start for 1 cycle:
  - Out=0x01, then 0x02…0x80, each held 2 cycles.
  - Then 0x01 with Wrap high exactly 1 cycle.
- Bounce, Div=1:
  - Out sequence 01,02,04,…,80,40,…,01 with Wrap at the returning 01.
  - Period is 14 steps.
- Fill, Div=1:
  - Out 01,03,07,…,FF,00,01 with Wrap on 01.
- Pause:
  - Pause=1 while Out=0x08, Div=3, for 10 cycles → Out stays 0x08, Busy=1.
  - After release, 0x10 appears after the remaining prescaler count, not a full 3.
- Edge cases:
  - Start+Pause same cycle → Out=initial pattern and frozen.
  - Div=0 → steps every cycle.
  - Mode changed mid-run without Start → pattern unchanged.
  - Reset mid-run → Out=0 on the next edge.

Source files
------------

// File: rtl/lpe_pkg.sv
// lpe_pkg: mode and state encodings shared by the light pattern engine.
package lpe_pkg;
    typedef enum logic [1:0] {
        MODE_SHL    = 2'd0,
        MODE_SHR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSED} state_t;
endpackage

// File: rtl/lpe_if.sv
// lpe_if: control inputs and LED outputs of the light pattern engine.
interface lpe_if #(parameter int WIDTH = 8, parameter int DIV_W = 16);
    logic             start;
    logic             pause;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             wrap;
    modport master (output start, pause, mode, div, input out, busy, wrap);
    modport slave  (input start, pause, mode, div, output out, busy, wrap);
endinterface

// File: rtl/lpe_prescaler.sv
// lpe_prescaler: step-rate counter; div of 0 behaves as 1.
module lpe_prescaler #(parameter int DIV_W = 16) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt, last;
    assign last = (div == '0) ? '0 : div - 1'b1;
    // >= so a shrinking div ticks at once instead of wrapping the counter
    assign tick = en && (cnt >= last);
    always_ff @(posedge clk)
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/light_pattern_engine.sv
// light_pattern_engine: WIDTH-bit animated LED bar (shift-left/right, bounce, fill).
module light_pattern_engine
    import lpe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input logic  clk,
    input logic  rst,
    lpe_if.slave bus
);
    state_t           state, state_n;
    mode_t            mode_q;
    logic             dir_left, dir_left_n;
    logic [WIDTH-1:0] out_q, init_pat, step_pat, bnc;
    logic             wrap_q, step_wrap, bnc_right, en, tick;

    assign en       = (state == ST_RUN) && !bus.pause && !bus.start;
    assign bus.out  = out_q;
    assign bus.wrap = wrap_q;
    assign bus.busy = (state != ST_IDLE);

    lpe_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(bus.start),
        .en   (en),
        .div  (bus.div),
        .tick (tick)
    );

    always_comb
        state_n = bus.start ? (bus.pause ? ST_PAUSED : ST_RUN) :
                  (state == ST_RUN && bus.pause) ? ST_PAUSED :
                  (state == ST_PAUSED && !bus.pause) ? ST_RUN : state;

    always_comb begin
        init_pat   = (mode_t'(bus.mode) == MODE_SHR) ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(1);
        // bounce turns around at the top without holding; arriving at bit0 ends the period
        bnc_right  = !(dir_left && !out_q[WIDTH-1]);
        bnc        = bnc_right ? out_q >> 1 : out_q << 1;
        dir_left_n = !bnc_right || bnc[0];
        step_pat   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        step_wrap  = out_q[WIDTH-1];
        case (mode_q)
            MODE_SHR: begin
                step_pat  = {out_q[0], out_q[WIDTH-1:1]};
                step_wrap = out_q[0];
            end
            MODE_BOUNCE: begin
                step_pat  = bnc;
                step_wrap = bnc_right && bnc[0];
            end
            MODE_FILL: begin
                step_pat  = (&out_q) ? '0 : {out_q[WIDTH-2:0], 1'b1};
                step_wrap = (out_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk)
        if (!rst) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_SHL;
            dir_left <= 1'b1;
            out_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state  <= state_n;
            wrap_q <= tick && step_wrap;
            if (bus.start) begin
                mode_q   <= mode_t'(bus.mode);
                out_q    <= init_pat;
                dir_left <= 1'b1;
            end else if (tick) begin
                out_q    <= step_pat;
                dir_left <= dir_left_n;
            end
        end
endmodule

// File: tb/tb_light_pattern_engine.sv
// tb_light_pattern_engine: directed literal checks plus random run against a step-index model.
module tb_light_pattern_engine;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    lpe_if #(.WIDTH(W), .DIV_W(16)) bus ();

    light_pattern_engine #(.WIDTH(W), .DIV_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model: state (0 idle, 1 run, 2 paused), steps since start, prescaler count
    int           m_st = 0;
    int           m_k = 0;
    int           m_cnt = 0;
    int           m_mode = 0;
    logic [W-1:0] m_out = '0;
    logic         m_wrap = 1'b0;

    function automatic logic [W-1:0] pat(input int md, input int k);
        int p;
        case (md)
            0: return W'(1) << (k % W);
            1: return W'(1) << (W - 1 - k % W);
            2: begin
                p = k % (2 * W - 2);
                return W'(1) << ((p < W) ? p : 2 * W - 2 - p);
            end
            default: begin
                p = k % (W + 1);
                return (p < W) ? W'((64'd1 << (p + 1)) - 1) : '0;
            end
        endcase
    endfunction

    function automatic bit wraps(input int md, input int k);
        return k > 0 && (k % ((md < 2) ? W : (md == 2) ? 2 * W - 2 : W + 1)) == 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk_en) begin
            chk("out", 32'(bus.out), 32'(m_out));
            chk("busy", 32'(bus.busy), 32'(m_st != 0));
            chk("wrap", 32'(bus.wrap), 32'(m_wrap));
        end

    task automatic cyc(input logic r, input logic s, input logic p, input logic [1:0] md, input int d);
        int de;
        rst       = r;
        bus.start = s;
        bus.pause = p;
        bus.mode  = md;
        bus.div   = 16'(d);
        @(posedge clk);
        de = (d == 0) ? 1 : d;
        if (!r) begin
            m_st = 0; m_cnt = 0; m_k = 0; m_mode = 0; m_out = '0; m_wrap = 1'b0;
        end else if (s) begin
            m_mode = md; m_cnt = 0; m_k = 0; m_out = pat(md, 0); m_wrap = 1'b0;
            m_st = p ? 2 : 1;
        end else begin
            m_wrap = 1'b0;
            if (m_st == 1 && p) m_st = 2;
            else if (m_st == 2 && !p) m_st = 1;
            else if (m_st == 1) begin
                if (m_cnt >= de - 1) begin
                    m_cnt = 0;
                    m_k++;
                    m_out  = pat(m_mode, m_k);
                    m_wrap = wraps(m_mode, m_k);
                end else m_cnt++;
            end
        end
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    logic pz = 1'b0;

    initial begin
        bus.start = 1'b0; bus.pause = 1'b0; bus.mode = 2'd0; bus.div = 16'd1;
        @(negedge clk);
        repeat (2) begin
            cyc(0, 1, 0, 0, 1);
            chk("rst_out", 32'(bus.out), 0);
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_wrap", 32'(bus.wrap), 0);
        end
        cyc(1, 0, 0, 0, 1);
        chk("idle_busy", 32'(bus.busy), 0);
        // shift-left, div 2; mode input wiggles without start
        cyc(1, 1, 0, 0, 2);
        chk("shl_init", 32'(bus.out), 32'h01);
        for (int n = 1; n <= 17; n++) begin
            cyc(1, 0, 0, 2'(n), 2);
            if (n == 1) chk("shl_hold", 32'(bus.out), 32'h01);
            if (n == 2) chk("shl_step", 32'(bus.out), 32'h02);
            if (n == 16) begin
                chk("shl_wrap_out", 32'(bus.out), 32'h01);
                chk("shl_wrap", 32'(bus.wrap), 1);
            end
            if (n == 17) chk("shl_wrap_pulse", 32'(bus.wrap), 0);
        end
        // bounce, div 1
        cyc(1, 1, 0, 2, 1);
        for (int n = 1; n <= 14; n++) begin
            cyc(1, 0, 0, 2, 1);
            if (n == 7) chk("bnc_top", 32'(bus.out), 32'h80);
            if (n == 8) chk("bnc_down", 32'(bus.out), 32'h40);
            if (n == 13) chk("bnc_nowrap", 32'(bus.wrap), 0);
            if (n == 14) begin
                chk("bnc_end", 32'(bus.out), 32'h01);
                chk("bnc_wrap", 32'(bus.wrap), 1);
            end
        end
        // fill, div 0
        cyc(1, 1, 0, 3, 0);
        for (int n = 1; n <= 9; n++) begin
            cyc(1, 0, 0, 3, 0);
            if (n == 1) chk("fill_03", 32'(bus.out), 32'h03);
            if (n == 7) chk("fill_ff", 32'(bus.out), 32'hff);
            if (n == 8) chk("fill_00", 32'(bus.out), 32'h00);
            if (n == 9) begin
                chk("fill_01", 32'(bus.out), 32'h01);
                chk("fill_wrap", 32'(bus.wrap), 1);
            end
        end
        // pause at 0x08 with one prescaler count already taken
        cyc(1, 1, 0, 0, 3);
        repeat (10) cyc(1, 0, 0, 0, 3);
        chk("pre_pause", 32'(bus.out), 32'h08);
        repeat (10) begin
            cyc(1, 0, 1, 0, 3);
            chk("pause_out", 32'(bus.out), 32'h08);
            chk("pause_busy", 32'(bus.busy), 1);
        end
        cyc(1, 0, 0, 0, 3);
        cyc(1, 0, 0, 0, 3);
        chk("resume_hold", 32'(bus.out), 32'h08);
        cyc(1, 0, 0, 0, 3);
        chk("resume_step", 32'(bus.out), 32'h10);
        // start with pause in the same cycle
        cyc(1, 1, 1, 1, 1);
        chk("sp_init", 32'(bus.out), 32'h80);
        repeat (5) cyc(1, 0, 1, 1, 1);
        chk("sp_frozen", 32'(bus.out), 32'h80);
        cyc(1, 0, 0, 1, 1);
        cyc(1, 0, 0, 1, 1);
        chk("shr_step", 32'(bus.out), 32'h40);
        cyc(0, 0, 0, 1, 1);
        chk("midrun_rst", 32'(bus.out), 0);
        chk("midrun_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) pz = ~pz;
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, pz,
                2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
